shreg_sequencer: RTL and testbench

Command-driven controller for a 4-bit 74194-style universal shift register. It accepts one operation at a time over a valid/ready handshake: parallel load, shift right N, shift left N, or Johnson-step N. It drives the register's mode (S1/S0), parallel and serial inputs for exactly the required number of clocks, then captures the register contents and pulses done. It sits between the lab's stimulus/control logic and the shift-register datapath.

---
 rtl/shreg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_shreg_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shreg_sequencer.sv
// Command sequencer for a 4-bit 74194-style universal shift register.
// Drives S1/S0, parallel and serial inputs for the required number of clocks, then captures q.
module shreg_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             cmd_ser,
    input  logic             pause,
    input  logic [3:0]       q,
    output logic             s1,
    output logic             s0,
    output logic [3:0]       par,
    output logic             rin,
    output logic             lin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_JOHN = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       mode_r;
    logic [3:0]       par_r;
    logic             rin_r;
    logic             lin_r;
    logic             john_r;
    logic             busy_r;
    logic             ready_r;
    logic             done_r;
    logic [3:0]       result_r;
    logic             run_hold_s;
    logic             lin_s;

    // Register mode (S1,S0) that carries out each command opcode.
    function automatic logic [1:0] op_mode(input logic [1:0] op);
        case (op)
            OP_LOAD: op_mode = 2'b11;
            OP_SHR:  op_mode = 2'b01;
            OP_SHL:  op_mode = 2'b10;
            OP_JOHN: op_mode = 2'b10;
            default: op_mode = 2'b00;
        endcase
    endfunction

    // Sequencer state, shift counter and registered register-side controls.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_r  <= IDLE;
            count_r  <= CNT_ZERO;
            mode_r   <= 2'b00;
            par_r    <= 4'b0000;
            rin_r    <= 1'b0;
            lin_r    <= 1'b0;
            john_r   <= 1'b0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            result_r <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (cmd_valid && ready_r) begin
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                        if (cmd_op == OP_LOAD) begin
                            state_r <= RUN;
                            count_r <= CNT_ONE;
                            mode_r  <= 2'b11;
                            par_r   <= cmd_data;
                        end else if (cmd_len != CNT_ZERO) begin
                            state_r <= RUN;
                            count_r <= cmd_len;
                            mode_r  <= op_mode(cmd_op);
                            rin_r   <= (cmd_op == OP_SHR) ? cmd_ser : 1'b0;
                            lin_r   <= (cmd_op == OP_SHL) ? cmd_ser : 1'b0;
                            john_r  <= (cmd_op == OP_JOHN);
                        end else begin
                            // Zero-length shift: register stays in hold, just report q.
                            state_r <= CAPTURE;
                        end
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (count_r == CNT_ONE) begin
                            state_r <= CAPTURE;
                            count_r <= CNT_ZERO;
                            mode_r  <= 2'b00;
                            par_r   <= 4'b0000;
                            rin_r   <= 1'b0;
                            lin_r   <= 1'b0;
                            john_r  <= 1'b0;
                        end else begin
                            count_r <= count_r - CNT_ONE;
                        end
                    end
                end
                CAPTURE: begin
                    result_r <= q;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= CNT_ZERO;
                    mode_r  <= 2'b00;
                    par_r   <= 4'b0000;
                    rin_r   <= 1'b0;
                    lin_r   <= 1'b0;
                    john_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Pause must hold the register in the very cycle it is asserted, so it masks the
    // registered mode; Johnson feedback follows q without a clock of delay.
    always_comb begin
        run_hold_s = 1'b0;
        lin_s      = lin_r;
        if ((state_r == RUN) && pause) begin
            run_hold_s = 1'b1;
        end else begin
            run_hold_s = 1'b0;
        end
        if (john_r) begin
            lin_s = ~q[3];
        end else begin
            lin_s = lin_r;
        end
    end

    assign s1        = mode_r[1] & ~run_hold_s;
    assign s0        = mode_r[0] & ~run_hold_s;
    assign par       = par_r;
    assign rin       = rin_r;
    assign lin       = lin_s;
    assign busy      = busy_r;
    assign cmd_ready = ready_r;
    assign done      = done_r;
    assign result    = result_r;

endmodule

// File: tb/tb_shreg_sequencer.sv
// Scoreboard bench for shreg_sequencer: a 74194 model closes the loop on q, and
// expected results come from closed-form shift/Johnson arithmetic.
module tb_shreg_sequencer;

    logic       clk;
    logic       CLR;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic       cmd_ser;
    logic       pause;
    logic [3:0] q;
    logic       s1;
    logic       s0;
    logic [3:0] par;
    logic       rin;
    logic       lin;
    logic       busy;
    logic       done;
    logic [3:0] result;

    typedef struct {
        logic [3:0] res;
        logic [1:0] mode;
        int         n;
        int         t_acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   shifts = 0;
    int   paused = 0;
    logic pause_rand = 1'b0;
    logic pause_force = 1'b0;

    shreg_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .cmd_ser   (cmd_ser),
        .pause     (pause),
        .q         (q),
        .s1        (s1),
        .s0        (s0),
        .par       (par),
        .rin       (rin),
        .lin       (lin),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 74194 behaviour: 11 load, 01 shift toward QD (rin enters QA), 10 shift toward QA (lin enters QD).
    always @(posedge clk) begin
        case ({s1, s0})
            2'b11:   q <= par;
            2'b01:   q <= {rin, q[3:1]};
            2'b10:   q <= {q[2:0], lin};
            default: q <= q;
        endcase
    end

    // Pause changes mid-cycle, well away from both clock edges.
    always @(posedge clk) begin
        #2;
        pause = pause_rand ? ($urandom_range(0, 2) == 0) : pause_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_result(input logic [1:0] op, input logic [3:0] data,
                                              input logic [3:0] len, input logic ser,
                                              input logic [3:0] q0);
        logic [7:0]  w;
        logic [11:0] j;
        int          k;
        k = (len > 4'd4) ? 4 : int'(len);
        case (op)
            2'b00: return data;
            2'b01: begin
                w = {{4{ser}}, q0} >> k;
                return w[3:0];
            end
            2'b10: begin
                w = {q0, {4{ser}}} << k;
                return w[7:4];
            end
            default: begin
                // Johnson stepping has period 8 and complements the word after 4 steps.
                j = {q0, ~q0, q0} << (int'(len) % 8);
                return j[11:8];
            end
        endcase
    endfunction

    function automatic logic [1:0] ref_mode(input logic [1:0] op);
        case (op)
            2'b00:   return 2'b11;
            2'b01:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Issue one command; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [3:0] len,
                        input logic ser);
        exp_t e;
        int   waited;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_ser   = ser;
        waited    = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", waited);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            e.res   = ref_result(op, data, len, ser, q);
            e.mode  = ref_mode(op);
            e.n     = (op == 2'b00) ? 1 : int'(len);
            e.t_acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, 32'({cmd_ready, s1, s0, par, rin, lin, busy, done, result}),
            32'({1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}));
    endtask

    // Monitor: tracks shift edges and pause cycles, pops the scoreboard on done.
    always @(negedge clk) begin
        if (!CLR) begin
            exp_q.delete();
            shifts = 0;
            paused = 0;
        end else begin
            chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                if (done) chk("spurious_done", 32'(done), 32'd0);
            end else if (done) begin
                cur_e = exp_q.pop_front();
                chk("result", 32'(result), 32'(cur_e.res));
                chk("shift_edges", 32'(shifts), 32'(cur_e.n));
                chk("latency", 32'(cyc - cur_e.t_acc), 32'(cur_e.n + 1 + paused));
                shifts = 0;
                paused = 0;
            end else if (cyc - exp_q[0].t_acc > 80) begin
                n_vec++;
                n_fail++;
                $display("FAIL done_timeout: no done within 80 cycles of accept");
                cur_e  = exp_q.pop_front();
                shifts = 0;
                paused = 0;
            end else if (pause && shifts < exp_q[0].n) begin
                paused++;
                chk("pause_hold", 32'({s1, s0}), 32'd0);
            end else if ({s1, s0} != 2'b00) begin
                shifts++;
                chk("mode", 32'({s1, s0}), 32'(exp_q[0].mode));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] walk [0:7];
        int         waited;
        walk = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        CLR = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 4'b0000;
        cmd_len = 4'd0;
        cmd_ser = 1'b0;
        pause = 1'b0;
        q = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset_state");
        #2;
        CLR = 1'b1;

        send(2'b00, 4'b1001, 4'd0, 1'b0);
        send(2'b00, 4'b0001, 4'd0, 1'b0);
        send(2'b10, 4'b0000, 4'd3, 1'b0);
        send(2'b00, 4'b0001, 4'd0, 1'b0);
        send(2'b01, 4'b0000, 4'd2, 1'b1);

        // Johnson walk from zero, checked step by step.
        send(2'b00, 4'b0000, 4'd0, 1'b0);
        send(2'b11, 4'b0000, 4'd8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("johnson_step%0d", k + 1), 32'(q), 32'(walk[k]));
        end

        // Two paused cycles in the middle of a 4-long fill.
        send(2'b00, 4'b0000, 4'd0, 1'b0);
        send(2'b10, 4'b0000, 4'd4, 1'b1);
        @(posedge clk);
        #1;
        pause_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pause_force = 1'b0;

        send(2'b01, 4'b0000, 4'd0, 1'b1);

        // Reset in the middle of a long shift aborts it.
        send(2'b10, 4'b0000, 4'd10, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        CLR = 1'b0;
        #1;
        check_reset_vals("reset_mid_run");
        @(posedge clk);
        #3;
        CLR = 1'b1;
        #1;
        chk("ready_after_clr", 32'(cmd_ready), 32'd1);
        send(2'b00, 4'b0110, 4'd0, 1'b0);

        pause_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom));
        end

        waited = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d commands never completed", exp_q.size());
        end
        pause_rand = 1'b0;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
